mux_rr_reg: RTL

Parametrised, registered N-input, WIDTH-bit selector for the KGP-RISC datapath. It picks one of N valid/ready source channels with round-robin or fixed-priority arbitration, then holds the chosen word in a one-entry output register until the consumer accepts it. It is used where several producers compete for one destination, such as writeback sources, register-file write port sharing and memory-request merging.

---
 rtl/mux_rr_reg_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/mux_rr_reg.sv | 88 ++++++++
 3 files changed

// File: rtl/mux_rr_reg_pkg.sv
// Shared constants for parametrised KGP-RISC datapath blocks.
// Provides clog2 and the source-index width derivation.
package mux_rr_reg_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Index width never collapses to zero, even for a single channel.
    function automatic int src_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr or fixed priority.
// Uses a double-width request vector so the wrap search is a single lowest-bit pick.
module rr_arbiter
    import mux_rr_reg_pkg::*;
#(
    parameter int N = 2,
    parameter int RR = 1,
    localparam int SRC_W = src_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_first;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (RR == 0) || (i >= int'(ptr));
        end
    end

    // Lower half: requests at or above ptr; upper half: all requests (wrap).
    assign w_dbl   = {req, req & w_mask};
    assign w_first = w_dbl & (~w_dbl + ONE);
    assign grant   = w_first[N-1:0] | w_first[2*N-1:N];

endmodule

// File: rtl/mux_rr_reg.sv
// Registered N-way valid/ready selector with round-robin or fixed priority.
// One-entry output register; a new word may replace the old one while it drains.
module mux_rr_reg
    import mux_rr_reg_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int N = 2,
    parameter int RR = 1,
    localparam int SRC_W = src_w(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SRC_W-1:0]   out_src,
    input  logic               out_ready
);

    logic [SRC_W-1:0] r_ptr;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SRC_W-1:0] r_src;

    logic             w_load_en;
    logic [N-1:0]     w_grant;
    logic             w_xfer;
    logic [SRC_W-1:0] w_gidx;
    logic [WIDTH-1:0] w_sel;
    logic [SRC_W-1:0] w_ptr_nxt;

    rr_arbiter #(
        .N  (N),
        .RR (RR)
    ) u_arb (
        .req   (in_valid),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    assign w_load_en = !r_valid || out_ready;
    assign in_ready  = w_grant & {N{w_load_en}};
    assign w_xfer    = |(in_valid & in_ready);

    // Grant is one-hot, so OR-reduction yields the winner's index and data.
    always_comb begin
        w_gidx = '0;
        w_sel  = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_gidx = w_gidx | SRC_W'(i);
                w_sel  = w_sel | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_ptr_nxt = '0;
        if (w_gidx != SRC_W'(N - 1)) begin
            w_ptr_nxt = w_gidx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_sel;
            r_src   <= w_gidx;
            if (RR != 0) begin
                r_ptr <= w_ptr_nxt;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule
